// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - value/control inputs and display pin outputs of the 7-segment scan driver
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blank_in;
    logic [6:0]                seg_out;
    logic                      dp_out;
    logic [NUM_DIGITS-1:0]     dig_sel;
    logic                      frame_done;

    modport master (
        output en, load, digits_in, dp_in, blank_in,
        input  seg_out, dp_out, dig_sel, frame_done
    );

    modport slave (
        input  en, load, digits_in, dp_in, blank_in,
        output seg_out, dp_out, dig_sel, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed hex 7-segment scanner with ghost guard and frame-aligned double buffer
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16,
    parameter int SEG_ACT_LOW  = 0,
    parameter int DIG_ACT_LOW  = 0,
    parameter int LZ_BLANK     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int DW    = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      DIV_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = {7{SEG_ACT_LOW != 0}};
    localparam logic                  DP_OFF     = (SEG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIG_ACT_LOW != 0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    logic [DW-1:0]          stg_dig_q, stg_dig_d;
    logic [NUM_DIGITS-1:0]  stg_dp_q, stg_dp_d;
    logic [NUM_DIGITS-1:0]  stg_blank_q, stg_blank_d;
    logic [DW-1:0]          disp_dig_q, disp_dig_d;
    logic [NUM_DIGITS-1:0]  disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]  disp_blank_q, disp_blank_d;
    logic                   pend_q, pend_d;

    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]  dig_q, dig_d;
    logic                   fd_q, fd_d;

    logic                   frame_end;
    logic [NUM_DIGITS-1:0]  lz_dark;
    logic [3:0]             cur_nib;
    logic                   cur_dark;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    // Last cycle of the final digit's slot: the only point where the display buffer may change while scanning.
    assign frame_end = (state_q == SHOW) && (idx_q == IDX_LAST) && (cnt_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                GUARD: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == GUARD_LAST) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt_q == DIV_LAST) begin
                        state_d = GUARD;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stg_dig_d    = stg_dig_q;
        stg_dp_d     = stg_dp_q;
        stg_blank_d  = stg_blank_q;
        disp_dig_d   = disp_dig_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;
        pend_d       = pend_q;
        if (bus.load) begin
            stg_dig_d   = bus.digits_in;
            stg_dp_d    = bus.dp_in;
            stg_blank_d = bus.blank_in;
            pend_d      = 1'b1;
        end
        if (frame_end) begin
            if (bus.load) begin
                disp_dig_d   = bus.digits_in;
                disp_dp_d    = bus.dp_in;
                disp_blank_d = bus.blank_in;
            end else if (pend_q) begin
                disp_dig_d   = stg_dig_q;
                disp_dp_d    = stg_dp_q;
                disp_blank_d = stg_blank_q;
            end
            pend_d = 1'b0;
        end else if (state_q == IDLE && bus.load) begin
            disp_dig_d   = bus.digits_in;
            disp_dp_d    = bus.dp_in;
            disp_blank_d = bus.blank_in;
        end
    end

    // Walk from the most significant digit down; the run stays set only while every digit so far reads as zero.
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_dark = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run = run & (disp_blank_q[i] | (disp_dig_q[4*i +: 4] == 4'h0));
            if (LZ_BLANK != 0 && i > 0) begin
                lz_dark[i] = run;
            end
        end
    end

    always_comb begin
        cur_nib  = disp_dig_q[4*int'(idx_q) +: 4];
        cur_dark = disp_blank_q[idx_q] | lz_dark[idx_q];
        seg_d    = SEG_OFF;
        dp_d     = DP_OFF;
        dig_d    = DIG_OFF;
        fd_d     = frame_end;
        if (state_q == SHOW) begin
            dig_d = (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF;
            if (!cur_dark) begin
                seg_d = hex7(cur_nib) ^ SEG_OFF;
                dp_d  = disp_dp_q[idx_q] ^ DP_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            stg_dig_q    <= '0;
            stg_dp_q     <= '0;
            stg_blank_q  <= '0;
            disp_dig_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            pend_q       <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            dig_q        <= DIG_OFF;
            fd_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stg_dig_q    <= stg_dig_d;
            stg_dp_q     <= stg_dp_d;
            stg_blank_q  <= stg_blank_d;
            disp_dig_q   <= disp_dig_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            pend_q       <= pend_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_q        <= dig_d;
            fd_q         <= fd_d;
        end
    end

    assign bus.seg_out    = seg_q;
    assign bus.dp_out     = dp_q;
    assign bus.dig_sel    = dig_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver, two parameter sets under shared stimulus
module tb_seg7_scan_driver;
    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int G     = 2;
    localparam int FRAME = N * DIV;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
        logic       fd;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  bl = '0;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus_a ();
    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus_b ();

    assign bus_a.en = en;
    assign bus_a.load = load;
    assign bus_a.digits_in = din;
    assign bus_a.dp_in = dp;
    assign bus_a.blank_in = bl;
    assign bus_b.en = en;
    assign bus_b.load = load;
    assign bus_b.digits_in = din;
    assign bus_b.dp_in = dp;
    assign bus_b.blank_in = bl;

    seg7_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(G),
        .SEG_ACT_LOW(0), .DIG_ACT_LOW(0), .LZ_BLANK(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(G),
        .SEG_ACT_LOW(1), .DIG_ACT_LOW(1), .LZ_BLANK(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
    );

    always #5 clk = ~clk;

    logic [6:0] dec_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Reference: scan position is a free-running cycle count since enable; slot and offset fall out of division.
    bit          m_active = 1'b0;
    int          m_p = 0;
    logic [15:0] m_disp = '0, m_stg = '0;
    logic [3:0]  m_dpd = '0, m_dps = '0, m_bd = '0, m_bs = '0;
    bit          m_pend = 1'b0;

    obs_t exp_a[$];
    obs_t exp_b[$];

    function automatic obs_t expect_out(input bit lz, input bit inv);
        obs_t o;
        int   slot, off;
        bit   allz, dark;
        o = '0;
        if (m_active) begin
            slot = (m_p / DIV) % N;
            off  = m_p % DIV;
            if (off >= G) begin
                o.dig = 4'b0001 << slot;
                allz = 1'b1;
                for (int j = slot; j < N; j++)
                    if (!(m_bd[j] || m_disp[4*j +: 4] == 4'h0)) allz = 1'b0;
                dark = m_bd[slot] || (lz && slot > 0 && allz);
                if (!dark) begin
                    o.seg = dec_tab[m_disp[4*slot +: 4]];
                    o.dp  = m_dpd[slot];
                end
            end
            o.fd = (slot == N - 1) && (off == DIV - 1);
        end
        if (inv) begin
            o.seg = ~o.seg;
            o.dp  = ~o.dp;
            o.dig = ~o.dig;
        end
        return o;
    endfunction

    initial begin
        bit fd;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_active = 1'b0; m_p = 0; m_pend = 1'b0;
                m_disp = '0; m_stg = '0; m_dpd = '0; m_dps = '0; m_bd = '0; m_bs = '0;
            end
            exp_a.push_back(expect_out(1'b0, 1'b0));
            exp_b.push_back(expect_out(1'b1, 1'b1));
            if (rst_n) begin
                fd = m_active && (m_p % FRAME == FRAME - 1);
                if (fd) begin
                    if (load) begin
                        m_disp = din; m_dpd = dp; m_bd = bl;
                    end else if (m_pend) begin
                        m_disp = m_stg; m_dpd = m_dps; m_bd = m_bs;
                    end
                end else if (!m_active && load) begin
                    m_disp = din; m_dpd = dp; m_bd = bl;
                end
                if (load) begin
                    m_stg = din; m_dps = dp; m_bs = bl;
                end
                m_pend = fd ? 1'b0 : (load ? 1'b1 : m_pend);
                if (!en) begin
                    m_active = 1'b0; m_p = 0;
                end else if (!m_active) begin
                    m_active = 1'b1; m_p = 0;
                end else begin
                    m_p++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
        end
    endtask

    initial begin
        obs_t ea, eb;
        forever begin
            @(negedge clk);
            if (exp_a.size() > 0) begin
                ea = exp_a.pop_front();
                eb = exp_b.pop_front();
                check("a_seg", {1'b0, bus_a.seg_out}, {1'b0, ea.seg});
                check("a_dp", {7'b0, bus_a.dp_out}, {7'b0, ea.dp});
                check("a_dig", {4'b0, bus_a.dig_sel}, {4'b0, ea.dig});
                check("a_fd", {7'b0, bus_a.frame_done}, {7'b0, ea.fd});
                check("b_seg", {1'b0, bus_b.seg_out}, {1'b0, eb.seg});
                check("b_dp", {7'b0, bus_b.dp_out}, {7'b0, eb.dp});
                check("b_dig", {4'b0, bus_b.dig_sel}, {4'b0, eb.dig});
                check("b_fd", {7'b0, bus_b.frame_done}, {7'b0, eb.fd});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] b);
        load = 1'b1; din = v; dp = p; bl = b;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_pos(input int pos);
        int k;
        k = 0;
        @(negedge clk);
        while (!(m_active && (m_p % FRAME == pos)) && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k >= 2 * FRAME) begin
            bad++;
            $display("FAIL wait_pos: position %0d not reached within %0d cycles", pos, k);
        end
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;
        do_load(16'h1234, 4'b0010, 4'b0000);
        en = 1'b1;
        step(3 * FRAME + 4);

        wait_pos(12);
        do_load(16'h5678, 4'b1000, 4'b0000);
        step(2 * FRAME);
        wait_pos(FRAME - 1);
        do_load(16'h9ABC, 4'b0001, 4'b0000);
        step(FRAME + 8);

        en = 1'b0;
        step(3);
        do_load(16'hABCD, 4'b0000, 4'b0000);
        en = 1'b1;
        step(FRAME + 8);

        do_load(16'h0070, 4'b0000, 4'b0000);
        step(2 * FRAME + 4);
        do_load(16'h0000, 4'b0101, 4'b0000);
        step(2 * FRAME + 4);
        do_load(16'h0305, 4'b0000, 4'b0100);
        step(2 * FRAME + 4);

        wait_pos(2 * DIV + 4);
        en = 1'b0;
        step(4);
        en = 1'b1;
        step(FRAME + 8);

        wait_pos(13);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(FRAME + 8);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            load = ($urandom_range(0, 11) == 0);
            din  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) din = din >> (4 * $urandom_range(1, 4));
            dp   = 4'($urandom);
            bl   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            if (en && $urandom_range(0, 199) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 5) == 0) en = 1'b1;
            rst_n = ($urandom_range(0, 599) != 0);
        end
        load = 1'b0;
        rst_n = 1'b1;
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
